barrett_reduce_pipe: RTL and testbench

//   Parametrised, pipelined Barrett modular reducer: R = C mod Q for any C < 2^IN_W.

---
 rtl/barrett_reduce_pipe_if.sv | 29 ++
 rtl/barrett_reduce_pipe.sv | 149 ++++++++++++++
 tb/tb_barrett_reduce_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_reduce_pipe_if.sv
// Handshake bundle for barrett_reduce_pipe: an operand stream in, a result stream out.
// RES_W is the width of the result word (OUT_W, or OUT_W+1 when BARRETT_LAZY_EN is defined).
`timescale 1ns/1ps
interface barrett_reduce_pipe_if #(
  parameter int unsigned IN_W  = 46,
  parameter int unsigned RES_W = 23,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_c;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_r;
  logic [TAG_W-1:0] out_tag;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_c, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag
  );

  // The reducer itself.
  modport slave (
    input  in_valid, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag
  );
endinterface

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: pipelined Barrett reduction R = C mod Q for C < 2^IN_W, with a
// pass-through tag and a global valid/ready stall.
// Optional feature macro: BARRETT_LAZY_EN -- drops the final correction stage, giving a
// 2-cycle latency and a result in [0, 2Q) that is OUT_W+1 bits wide.
`timescale 1ns/1ps
module barrett_reduce_pipe #(
  parameter int unsigned Q     = 8380417,
  parameter int unsigned IN_W  = 46,
  parameter int unsigned OUT_W = 23,
  parameter int unsigned TAG_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  barrett_reduce_pipe_if.slave bus
);

  localparam int unsigned K  = IN_W;
  localparam int unsigned MW = K - OUT_W + 2;
  localparam int unsigned PW = IN_W + MW;
  // r0 lies in [0, 3Q) and 3Q < 2^(OUT_W+2), so OUT_W+2 low bits carry the exact value.
  localparam int unsigned XW = OUT_W + 2;
`ifdef BARRETT_LAZY_EN
  localparam int unsigned RES_W = OUT_W + 1;
`else
  localparam int unsigned RES_W = OUT_W;
`endif

  localparam logic [K:0]    POW_K = {1'b1, {K{1'b0}}};
  localparam logic [K:0]    Q_K   = (K+1)'(Q);
  localparam logic [K:0]    M_K   = POW_K / Q_K;
  localparam logic [PW-1:0] M_P   = PW'(M_K);
  localparam logic [XW-1:0] Q_X   = XW'(Q);

  // One conditional subtraction of Q.
  function automatic logic [XW-1:0] cond_sub(input logic [XW-1:0] x);
    logic [XW-1:0] y;
    if (x >= Q_X) begin
      y = x - Q_X;
    end else begin
      y = x;
    end
    return y;
  endfunction

  logic             adv_s;
  logic [PW-1:0]    p_s;
  logic [XW-1:0]    tq_s;
  logic [XW-1:0]    r0_s;
  logic [XW-1:0]    r1_s;

  logic             s1_valid_r;
  logic [XW-1:0]    s1_c_r;
  logic [XW-1:0]    s1_t_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             out_valid_r;
  logic [RES_W-1:0] out_r_r;
  logic [TAG_W-1:0] out_tag_r;

  // Whole pipeline moves together; it only freezes when a result is waiting unconsumed.
  assign adv_s         = ~out_valid_r | bus.out_ready;
  assign bus.in_ready  = adv_s & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_r     = out_r_r;
  assign bus.out_tag   = out_tag_r;

  // Stage-1 datapath: full product C*M; only bits [K+XW-1:K] of it (the quotient estimate's low bits) matter later.
  always_comb begin
    p_s = PW'(bus.in_c) * M_P;
  end

  // Stage 1: capture the low bits of C and the quotient estimate t = (C*M) >> K.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_c_r     <= '0;
      s1_t_r     <= '0;
      s1_tag_r   <= '0;
    end else if (adv_s) begin
      s1_valid_r <= bus.in_valid;
      s1_c_r     <= XW'(bus.in_c);
      s1_t_r     <= XW'(p_s >> K);
      s1_tag_r   <= bus.in_tag;
    end
  end

  // Stage-2 datapath: r0 = C - t*Q computed modulo 2^XW (exact since r0 < 3Q), then one correction.
  always_comb begin
    tq_s = s1_t_r * Q_X;
    r0_s = s1_c_r - tq_s;
    r1_s = cond_sub(r0_s);
  end

`ifdef BARRETT_LAZY_EN

  // Stage 2 is the output register: lazily reduced result in [0, 2Q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_r_r     <= '0;
      out_tag_r   <= '0;
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      out_r_r     <= RES_W'(r1_s);
      out_tag_r   <= s1_tag_r;
    end
  end

`else

  logic             s2_valid_r;
  logic [OUT_W:0]   s2_r1_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic [XW-1:0]    r2_s;

  // Stage 2: hold the once-corrected remainder r1 in [0, 2Q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_r1_r    <= '0;
      s2_tag_r   <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_r1_r    <= (OUT_W+1)'(r1_s);
      s2_tag_r   <= s1_tag_r;
    end
  end

  // Stage-3 datapath: final correction brings the result into [0, Q).
  always_comb begin
    r2_s = cond_sub(XW'(s2_r1_r));
  end

  // Stage 3 is the output register: fully reduced result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_r_r     <= '0;
      out_tag_r   <= '0;
    end else if (adv_s) begin
      out_valid_r <= s2_valid_r;
      out_r_r     <= RES_W'(r2_s);
      out_tag_r   <= s2_tag_r;
    end
  end

`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe: a Dilithium-sized instance (Q=8380417) and a
// Kyber-sized instance (Q=3329). Inputs change 1ns after the rising edge; results are
// checked on the falling edge against a scoreboard of hand-computed or C%Q expectations.
`timescale 1ns/1ps
module tb_barrett_reduce_pipe;

  localparam int unsigned Q      = 8380417;
  localparam int unsigned IN_W   = 46;
  localparam int unsigned OUT_W  = 23;
  localparam int unsigned SQ     = 3329;
  localparam int unsigned S_IN_W = 24;
  localparam int unsigned S_OUT_W = 12;
  localparam int unsigned TAG_W  = 8;
`ifdef BARRETT_LAZY_EN
  localparam int unsigned RES_W   = OUT_W + 1;
  localparam int unsigned S_RES_W = S_OUT_W + 1;
  localparam int unsigned LAT     = 2;
`else
  localparam int unsigned RES_W   = OUT_W;
  localparam int unsigned S_RES_W = S_OUT_W;
  localparam int unsigned LAT     = 3;
`endif

  typedef struct {
    logic [63:0] c;
    logic [7:0]  tag;
    logic [63:0] exp;
  } vec_t;

  logic clk;
  logic rst;

  barrett_reduce_pipe_if #(.IN_W(IN_W), .RES_W(RES_W), .TAG_W(TAG_W)) bi ();
  barrett_reduce_pipe_if #(.IN_W(S_IN_W), .RES_W(S_RES_W), .TAG_W(TAG_W)) si ();

  barrett_reduce_pipe #(.Q(Q), .IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bi)
  );
  barrett_reduce_pipe #(.Q(SQ), .IN_W(S_IN_W), .OUT_W(S_OUT_W), .TAG_W(TAG_W)) dut_s (
    .clk(clk), .rst(rst), .bus(si)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   pops = 0;
  int   stalls = 0;
  vec_t sb_q[$];
  vec_t ss_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Result check: exact remainder, or in lazy mode any representative below 2q.
  task automatic chk_r(input string nm, input logic [63:0] act, input logic [63:0] exp,
                       input logic [63:0] q);
    bit ok;
`ifdef BARRETT_LAZY_EN
    ok = (act < 2 * q) && ((act % q) == exp);
`else
    ok = (act === exp);
`endif
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (mod %0d)", nm, act, exp, q);
    end
  endtask

  // Scoreboards: every delivered result must match the oldest outstanding operand.
  always @(negedge clk) begin
    vec_t e;
    if (!rst && bi.out_valid && bi.out_ready) begin
      pops++;
      if (sb_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_extra: got result %0d with nothing outstanding, expected no output", bi.out_r);
      end else begin
        e = sb_q.pop_front();
        chk_r("sb_r", 64'(bi.out_r), e.exp, 64'(Q));
        chk("sb_tag", 64'(bi.out_tag), 64'(e.tag));
      end
    end
    if (!rst && si.out_valid && si.out_ready) begin
      if (ss_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ss_extra: got result %0d with nothing outstanding, expected no output", si.out_r);
      end else begin
        e = ss_q.pop_front();
        chk_r("ss_r", 64'(si.out_r), e.exp, 64'(SQ));
        chk("ss_tag", 64'(si.out_tag), 64'(e.tag));
      end
    end
  end

  // Present one operand to the big instance and return just after the edge that accepts it.
  task automatic send(input logic [63:0] c, input logic [7:0] tag, input logic [63:0] exp);
    int w;
    vec_t e;
    bi.in_valid = 1'b1;
    bi.in_c     = IN_W'(c);
    bi.in_tag   = tag;
    w = 0;
    while (!bi.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
    end else begin
      stalls += w;
      @(posedge clk); #1;
      e = '{c, tag, exp};
      sb_q.push_back(e);
    end
  endtask

  // Same for the small instance.
  task automatic send_s(input logic [63:0] c, input logic [7:0] tag, input logic [63:0] exp);
    int w;
    vec_t e;
    si.in_valid = 1'b1;
    si.in_c     = S_IN_W'(c);
    si.in_tag   = tag;
    w = 0;
    while (!si.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL send_s_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
    end else begin
      @(posedge clk); #1;
      e = '{c, tag, exp};
      ss_q.push_back(e);
    end
  endtask

  // Single isolated operand: check latency, value and tag at the moment out_valid rises.
  task automatic directed(input vec_t v);
    int lat;
    send(v.c, v.tag, v.exp);
    bi.in_valid = 1'b0;
    lat = 1;
    while (!bi.out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("dir_latency", 64'(lat), 64'(LAT));
    chk_r("dir_r", 64'(bi.out_r), v.exp, 64'(Q));
    chk("dir_tag", 64'(bi.out_tag), 64'(v.tag));
    @(posedge clk); #1;
  endtask

  task automatic directed_s(input vec_t v);
    int lat;
    send_s(v.c, v.tag, v.exp);
    si.in_valid = 1'b0;
    lat = 1;
    while (!si.out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("dir_s_latency", 64'(lat), 64'(LAT));
    chk_r("dir_s_r", 64'(si.out_r), v.exp, 64'(SQ));
    chk("dir_s_tag", 64'(si.out_tag), 64'(v.tag));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || ss_q.size() != 0) && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk(nm, 64'(sb_q.size() + ss_q.size()), 64'd0);
  endtask

  vec_t        dv[8];
  vec_t        sv[3];
  logic [63:0] c;
  logic [63:0] bp_c[3];
  int          p0;

  initial begin
    dv[0] = '{64'd8380417,        8'd1, 64'd0};
    dv[1] = '{64'd8380418,        8'd2, 64'd1};
    dv[2] = '{64'd10,             8'd3, 64'd10};
    dv[3] = '{64'd0,              8'd4, 64'd0};
    dv[4] = '{64'd70368744177663, 8'd5, 64'd49144};
    dv[5] = '{64'd70231372333056, 8'd6, 64'd1};
    dv[6] = '{64'd25141250,       8'd7, 64'd8380416};
    dv[7] = '{64'd8380416,        8'd8, 64'd8380416};
    sv[0] = '{64'd11082241,       8'd1, 64'd0};
    sv[1] = '{64'd3330,           8'd2, 64'd1};
    sv[2] = '{64'd16777215,       8'd3, 64'd2384};

    rst = 1'b1;
    bi.in_valid = 1'b0; bi.in_c = '0; bi.in_tag = '0; bi.out_ready = 1'b1;
    si.in_valid = 1'b0; si.in_c = '0; si.in_tag = '0; si.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_out_valid", 64'(bi.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bi.in_ready), 64'd0);
    chk("rst_out_r", 64'(bi.out_r), 64'd0);
    chk("rst_out_tag", 64'(bi.out_tag), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bi.in_ready), 64'd1);

    // Directed vectors, one at a time.
    for (int i = 0; i < 8; i++) directed(dv[i]);

    // Full-rate stream with incrementing tags.
    stalls = 0;
    p0 = pops;
    for (int i = 0; i < 1000; i++) begin
      c = {32'($urandom), 32'($urandom)};
      c = c & ((64'd1 << IN_W) - 64'd1);
      if (i % 97 == 0) c = (64'd1 << IN_W) - 64'd1 - 64'(i);
      send(c, 8'(i), c % 64'(Q));
    end
    bi.in_valid = 1'b0;
    drain("stream_drain");
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_count", 64'(pops - p0), 64'd1000);

    // Backpressure with the pipeline full.
    bp_c[0] = 64'd12345678901;
    bp_c[1] = 64'd41902092;
    bp_c[2] = 64'd999;
    bi.out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < int'(LAT); i++) send(bp_c[i], 8'(8'd200 + 8'(i)), bp_c[i] % 64'(Q));
    bi.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(bi.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bi.out_valid), 64'd1);
      chk_r("bp_out_r_frozen", 64'(bi.out_r), bp_c[0] % 64'(Q), 64'(Q));
      chk("bp_out_tag_frozen", 64'(bi.out_tag), 64'd200);
    end
    bi.out_ready = 1'b1;
    drain("bp_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_count", 64'(pops - p0), 64'(LAT));

    // Reset with operands in flight.
    send(64'd77777777, 8'd50, 64'd77777777 % 64'(Q));
    send(64'd123456789012, 8'd51, 64'd123456789012 % 64'(Q));
    bi.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", 64'(bi.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bi.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 64'(bi.out_valid), 64'd0);
    end
    directed('{64'd5, 8'd9, 64'd5});

    // Kyber-sized instance.
    for (int i = 0; i < 3; i++) directed_s(sv[i]);
    for (int i = 0; i < 60; i++) begin
      c = 64'($urandom_range(0, (1 << S_IN_W) - 1));
      send_s(c, 8'(i), c % 64'(SQ));
    end
    si.in_valid = 1'b0;
    drain("small_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
